// File: rtl/memory_access_ctrl.sv
// Load/store front-end for the single-port data memory: valid/ready requests, held responses, saturating counters.
// Optional store acknowledgements are enabled with `define MEMORY_ACCESS_CTRL_WRITE_ACK_EN.
module memory_access_ctrl #(
  parameter int unsigned A = 7,
  parameter int unsigned D = 8,
  parameter int unsigned C = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [A-1:0] req_addr,
  input  logic [D-1:0] req_wdata,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [D-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_ce,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [D-1:0] mem_data,
  input  logic [D-1:0] mem_q,
  output logic [C-1:0] rd_cnt,
  output logic [C-1:0] wr_cnt
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t       state;
  logic [A-1:0] pend_addr;
  logic         accept;

  assign req_ready = (state == IDLE);
  // Gating with rst_n keeps the memory quiet while reset holds the FSM in IDLE.
  assign accept    = req_valid & req_ready & rst_n;
  assign mem_ce    = accept;
  assign mem_we    = accept & req_we;
  assign mem_addr  = req_addr;
  assign mem_data  = req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
    end else begin
      if (accept && !req_we && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      if (accept &&  req_we && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (!req_we) begin
              pend_addr <= req_addr;
              state     <= RD_WAIT;
            end else begin
`ifdef MEMORY_ACCESS_CTRL_WRITE_ACK_EN
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= (req_addr == '0);
              state     <= RSP;
`else
              state     <= IDLE;
`endif
            end
          end
        end
        RD_WAIT: begin
          rsp_rdata <= (pend_addr == '0) ? '0 : mem_q;
          rsp_err   <= (pend_addr == '0);
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Directed plus randomized bench for memory_access_ctrl against a transaction-level model and a memory stand-in.
// A second instance with 2-bit counters exercises saturation within a short run.
module tb_memory_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_we, rsp_ready;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] mem_q;

  logic        req_ready, rsp_valid, rsp_err, mem_ce, mem_we;
  logic [7:0]  rsp_rdata, mem_data;
  logic [6:0]  mem_addr;
  logic [15:0] rd_cnt, wr_cnt;

  logic        req_ready_s, rsp_valid_s, rsp_err_s, mem_ce_s, mem_we_s;
  logic [7:0]  rsp_rdata_s, mem_data_s;
  logic [6:0]  mem_addr_s;
  logic [1:0]  rd_cnt_s, wr_cnt_s;

  int unsigned tests = 0;
  int unsigned failed = 0;
  int unsigned ref_rd = 0;
  int unsigned ref_wr = 0;
  logic [7:0]  ref_mem [128];
  logic [7:0]  smem [128];
  logic [6:0]  q_addr = '0;

  always #5 clk = ~clk;

  memory_access_ctrl #(.A(7), .D(8), .C(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_q(mem_q), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  memory_access_ctrl #(.A(7), .D(8), .C(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_s), .rsp_err(rsp_err_s),
    .mem_ce(mem_ce_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_data(mem_data_s),
    .mem_q(mem_q), .rd_cnt(rd_cnt_s), .wr_cnt(wr_cnt_s)
  );

  // Memory stand-in without a hard-wired zero at address 0, so the block's own forcing is visible.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) smem[mem_addr] <= mem_data;
      q_addr <= mem_addr;
    end
  end
  assign mem_q = smem[q_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned n, input int unsigned w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic check_cnt(input string tag);
    check({tag, "_rd_cnt"}, 32'(rd_cnt), sat(ref_rd, 16));
    check({tag, "_wr_cnt"}, 32'(wr_cnt), sat(ref_wr, 16));
    check({tag, "_rd_cnt_s"}, 32'(rd_cnt_s), sat(ref_rd, 2));
    check({tag, "_wr_cnt_s"}, 32'(wr_cnt_s), sat(ref_wr, 2));
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [7:0] d, input logic e);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
    check({tag, "_rsp_valid_s"}, 32'(rsp_valid_s), 32'(v));
    if (v) begin
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(d));
      check({tag, "_rsp_rdata_s"}, 32'(rsp_rdata_s), 32'(d));
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'(e));
      check({tag, "_rsp_err_s"}, 32'(rsp_err_s), 32'(e));
    end
  endtask

  task automatic check_mem(input string tag, input logic ce, input logic we, input logic rdy);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(rdy));
    check({tag, "_req_ready_s"}, 32'(req_ready_s), 32'(rdy));
    check({tag, "_mem_ce"}, 32'(mem_ce), 32'(ce));
    check({tag, "_mem_ce_s"}, 32'(mem_ce_s), 32'(ce));
    check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    check({tag, "_mem_we_s"}, 32'(mem_we_s), 32'(we));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(req_addr));
    check({tag, "_mem_addr_s"}, 32'(mem_addr_s), 32'(req_addr));
    check({tag, "_mem_data"}, 32'(mem_data), 32'(req_wdata));
    check({tag, "_mem_data_s"}, 32'(mem_data_s), 32'(req_wdata));
  endtask

  // Waits in a held response; requests are offered and must be refused.
  task automatic hold_and_release(input string tag, input int unsigned hold,
                                  input logic [7:0] d, input logic e);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'(($urandom)); req_addr = 7'($urandom); #1;
      check_rsp({tag, "_hold"}, 1'b1, d, e);
      check_mem({tag, "_hold"}, 1'b0, 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0; #1;
    check_rsp({tag, "_done"}, 1'b0, 8'h00, 1'b0);
    check_mem({tag, "_done"}, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_load(input string tag, input logic [6:0] a, input int unsigned hold);
    logic [7:0] exp_d;
    logic       exp_e;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'($urandom);
    rsp_ready = 1'($urandom); #1;
    check_mem({tag, "_acc"}, 1'b1, 1'b0, 1'b1);
    exp_e = (a == 7'd0);
    exp_d = exp_e ? 8'h00 : ref_mem[a];
    ref_rd++;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'($urandom); req_addr = 7'($urandom); rsp_ready = 1'b1; #1;
    check_rsp({tag, "_wait"}, 1'b0, 8'h00, 1'b0);
    check_mem({tag, "_wait"}, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rsp_ready = 1'b0; #1;
    check_rsp({tag, "_t2"}, 1'b1, exp_d, exp_e);
    check_cnt(tag);
    hold_and_release(tag, hold, exp_d, exp_e);
  endtask

  task automatic do_store(input string tag, input logic [6:0] a, input logic [7:0] d,
                          input int unsigned hold);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    rsp_ready = 1'($urandom); #1;
    check_mem({tag, "_acc"}, 1'b1, 1'b1, 1'b1);
    ref_mem[a] = d;
    ref_wr++;
    @(posedge clk); #1;
    check_cnt(tag);
`ifdef MEMORY_ACCESS_CTRL_WRITE_ACK_EN
    req_valid = 1'b1; req_we = 1'($urandom); req_addr = 7'($urandom); rsp_ready = 1'b0; #1;
    check_rsp({tag, "_ack"}, 1'b1, 8'h00, (a == 7'd0));
    check_mem({tag, "_ack"}, 1'b0, 1'b0, 1'b0);
    hold_and_release(tag, hold, 8'h00, (a == 7'd0));
`else
    check_rsp({tag, "_noack"}, 1'b0, 8'h00, 1'b0);
    check(({tag, "_hold_unused"}), 32'(hold <= 32'd8), 32'd1);
`endif
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      req_valid = 1'b0; req_we = 1'($urandom); rsp_ready = 1'($urandom); #1;
      check_mem("idle", 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      smem[i]    = ref_mem[i];
    end
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h12; req_wdata = 8'h33;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_rsp("reset", 1'b0, 8'h00, 1'b0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check_cnt("reset");
    check("reset_mem_ce", 32'(mem_ce), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1; #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    do_store("st_a5", 7'h12, 8'hA5, 0);
    do_load("ld_12", 7'h12, 0);

    do_store("st_zero", 7'h00, 8'hFF, 1);
    do_load("ld_zero", 7'h00, 0);

    do_load("ld_hold5", 7'h05, 5);

    for (int unsigned i = 1; i <= 4; i++)
      do_store("b2b", 7'(i), 8'($urandom), 0);
    idle(1);
    check_cnt("b2b_end");

    // Reset arriving while the load sits in RD_WAIT must drop the response.
    do_load("pre_rst", 7'h03, 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h07; #1;
    @(posedge clk); #1;
    req_valid = 1'b1; rst_n = 1'b0; #1;
    ref_rd = 0; ref_wr = 0;
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_mid_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mid_mem_ce", 32'(mem_ce), 32'd0);
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check_cnt("rst_mid");
    @(posedge clk); #1;
    check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_hold_mem_ce", 32'(mem_ce), 32'd0);
    req_valid = 1'b0; rst_n = 1'b1; #1;
    check("rst_rel_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_after_req_ready", 32'(req_ready), 32'd1);

    for (int unsigned i = 0; i < 5; i++)
      do_load("sat", 7'($urandom), 0);
    check_cnt("sat_end");

    for (int unsigned i = 0; i < 40; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom);
      if ($urandom_range(0, 1) == 1) do_store("rnd_st", a, 8'($urandom), $urandom_range(0, 3));
      else                           do_load("rnd_ld", a, $urandom_range(0, 3));
    end
    idle(2);
    check_cnt("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/memory_access_ctrl.md
# memory_access_ctrl

Request/response front-end that sits directly upstream of the single-port data memory and is the only block that drives that memory's `ce`/`we`/`addr`/`data` pins. It accepts load/store requests from the datapath over a valid/ready handshake and sequences each access against the memory's one-cycle registered-address read. It returns read data through a held response register and keeps saturating access counters. Address 0 is hard-wired zero in the memory. This block reports stores to address 0 and forces loads from address 0 to return 0.

## Interface
- `A`, 7, address width; must match the memory.
- `D`, 8, data width; must match the memory.
- `C`, 16, width of each access counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  A  access address.
- `req_wdata`  in  D  store data.
- `rsp_valid`  out  1  response held on `rsp_rdata`/`rsp_err`.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  D  load data; 0 for store acks.
- `rsp_err`  out  1  access targeted address 0.
- `mem_ce`  out  1  to memory `ce`.
- `mem_we`  out  1  to memory `we`.
- `mem_addr`  out  A  to memory `addr`.
- `mem_data`  out  D  to memory `data`.
- `mem_q`  in  D  from memory `q`.
- `rd_cnt`  out  C  accepted loads, saturating at 2^C-1.
- `wr_cnt`  out  C  accepted stores, saturating at 2^C-1.

## Operation
- FSM states are IDLE, RD_WAIT and RSP.
- **IDLE:** `req_ready`=1.
  - On accept (`req_valid & req_ready`), drive `mem_ce`=1, `mem_we`=`req_we`, `mem_addr`=`req_addr` and `mem_data`=`req_wdata` combinationally in the same cycle.
  - Outside an accept, `mem_ce`=0 and `mem_we`=0.
  - `mem_addr`/`mem_data` follow `req_addr`/`req_wdata` at all times.
- **Load accept:** latch the address into `pend_addr`, then IDLE→RD_WAIT.
- **RD_WAIT:** `req_ready`=0 and `mem_ce`=0.
  - Capture `rsp_rdata` = (`pend_addr`==0) ? 0 : `mem_q`.
  - Capture `rsp_err` = (`pend_addr`==0).
  - Set `rsp_valid`=1, then RD_WAIT→RSP.
- **RSP:** `req_ready`=0; `rsp_valid`, `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`=1, clear `rsp_valid` at the edge and go RSP→IDLE.
  - A new request can be accepted no earlier than the following cycle.
- **Store accept:** behaviour depends on `WRITE_ACK_EN` (see Configuration).
- **Counters:** `rd_cnt`/`wr_cnt` increment by 1 on each accepted load/store and hold at all-ones.
- **Reset** (asserted at any time, including mid-access):
  - FSM→IDLE; any pending response is discarded.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rd_cnt`=0, `wr_cnt`=0, `pend_addr`=0.
  - `mem_ce`=0 and `mem_we`=0 for as long as `rst_n`=0.

## Timing
- **Load accepted in cycle T:**
  - Memory registers the address at the end of T.
  - `mem_q` is valid in T+1 and captured at the end of T+1.
  - `rsp_valid`=1 from T+2.
  - Load latency is 2 cycles; best-case load throughput is 1 per 3 cycles.
- **Store accepted in cycle T:** the memory writes at the end of T.
- **Handshakes:**
  - `req_ready` depends only on FSM state; it is never combinationally dependent on `req_valid`.
  - `rsp_valid`, once asserted, stays high until the `rsp_valid & rsp_ready` edge.
  - `rsp_ready` is ignored when `rsp_valid`=0.
- **After reset release:** IDLE on the first edge with `rst_n`=1, with `req_ready`=1 in that cycle.

## Configuration
- **`MEMORY_ACCESS_CTRL_WRITE_ACK_EN` defined:**
  - A store accept goes IDLE→RSP.
  - At the end of T: `rsp_valid`=1, `rsp_rdata`=0, `rsp_err`=(`req_addr`==0).
  - The ack is held until `rsp_ready`; store throughput is 1 per 2 cycles at best.
- **Not defined:**
  - Stores stay in IDLE with no response and no `rsp_err`.
  - Back-to-back stores proceed at 1 per cycle.

## Test plan
- Store 0xA5 to address 0x12, then load 0x12 with `rsp_ready`=1 → `rsp_valid` at load T+2 for one cycle, `rsp_rdata`=0xA5, `rsp_err`=0, `rd_cnt`=1, `wr_cnt`=1.
- Store 0xFF to address 0 then load address 0 → `rsp_rdata`=0x00 and `rsp_err`=1. With `WRITE_ACK_EN` defined, the store ack also has `rsp_err`=1.
- Load 0x05 with `rsp_ready` held 0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 and `mem_ce`=0 throughout. On the `rsp_ready` edge, IDLE follows with `req_ready`=1 the next cycle.
- With `WRITE_ACK_EN` undefined, 4 back-to-back stores to 0x01..0x04 → `mem_ce`=`mem_we`=1 for 4 consecutive cycles, no `rsp_valid`, `wr_cnt`=4.
- Assert `rst_n`=0 in the RD_WAIT cycle of a load → `rsp_valid` never rises, all outputs and counters read 0, and `req_ready`=1 on the first cycle after release.
- Force `rd_cnt` to 2^C-2 and issue 3 loads → `rd_cnt` saturates at 0xFFFF and holds.
